// File: rtl/uart_tx_frame_serializer_pkg.sv
//==============================================================================
// uart_tx_frame_serializer_pkg : shared FSM states and parity-type constants
// Rev 1.0
//==============================================================================
`default_nettype none

package uart_tx_frame_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_serializer_if.sv
//==============================================================================
// uart_tx_frame_serializer_if : command, mode, tick and line signals of the TX
// Rev 1.0
//==============================================================================
`default_nettype none

interface uart_tx_frame_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             data_ready;
  logic             bit_tick;
  logic             par_en;
  logic             par_typ;
  logic             stop2;
  logic             msb_first;
  logic             tx_out;
  logic             busy;
  logic             frame_done;

  modport master (
    output data, data_valid, bit_tick, par_en, par_typ, stop2, msb_first,
    input  data_ready, tx_out, busy, frame_done
  );

  modport slave (
    input  data, data_valid, bit_tick, par_en, par_typ, stop2, msb_first,
    output data_ready, tx_out, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_frame_serializer_parity.sv
//==============================================================================
// uart_tx_frame_serializer_parity : combinational parity of a word, even or odd
// Rev 1.0
//==============================================================================
`default_nettype none

module uart_tx_frame_serializer_parity
  import uart_tx_frame_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             parity
);
  assign parity = (par_typ == PAR_ODD) ? ~^data : ^data;
endmodule

`default_nettype wire

// File: rtl/uart_tx_frame_serializer.sv
//==============================================================================
// uart_tx_frame_serializer : one-deep holding buffer plus UART framing FSM
// Rev 1.0
//==============================================================================
`default_nettype none

module uart_tx_frame_serializer
  import uart_tx_frame_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_frame_serializer_if.slave   bus
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  tx_state_e        state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt, shreg, shreg_nxt;
  logic             hold_full, hold_full_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stp, stp_nxt;
  logic             par_en_l, par_en_nxt;
  logic             stop2_l, stop2_nxt;
  logic             msb_l, msb_nxt;
  logic             parity_l, parity_nxt;
  logic             tx_r, tx_nxt;
  logic             done_r, done_nxt;
  logic             load;
  logic             hold_parity;

  uart_tx_frame_serializer_parity #(.WIDTH(WIDTH)) u_parity (
    .data    (hold),
    .par_typ (bus.par_typ),
    .parity  (hold_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      stp       <= 1'b0;
      par_en_l  <= 1'b0;
      stop2_l   <= 1'b0;
      msb_l     <= 1'b0;
      parity_l  <= 1'b0;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      stp       <= stp_nxt;
      par_en_l  <= par_en_nxt;
      stop2_l   <= stop2_nxt;
      msb_l     <= msb_nxt;
      parity_l  <= parity_nxt;
      tx_r      <= tx_nxt;
      done_r    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    shreg_nxt     = shreg;
    cnt_nxt       = cnt;
    stp_nxt       = stp;
    par_en_nxt    = par_en_l;
    stop2_nxt     = stop2_l;
    msb_nxt       = msb_l;
    parity_nxt    = parity_l;
    done_nxt      = 1'b0;
    load          = 1'b0;
    tx_nxt        = 1'b1;

    if (bus.data_valid && !hold_full) begin
      hold_nxt      = bus.data;
      hold_full_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      ST_START: begin
        if (bus.bit_tick) begin
          state_nxt = ST_DATA;
          cnt_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (bus.bit_tick) begin
          shreg_nxt = msb_l ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          cnt_nxt   = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nxt = par_en_l ? ST_PARITY : ST_STOP;
            stp_nxt   = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (bus.bit_tick) begin
          state_nxt = ST_STOP;
          stp_nxt   = 1'b0;
        end
      end
      ST_STOP: begin
        if (bus.bit_tick) begin
          if (stop2_l && !stp) begin
            stp_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
            if (hold_full) load = 1'b1;
            else           state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Loading snapshots the mode so later input changes cannot corrupt the frame.
    if (load) begin
      state_nxt     = ST_START;
      shreg_nxt     = hold;
      hold_full_nxt = 1'b0;
      cnt_nxt       = '0;
      stp_nxt       = 1'b0;
      par_en_nxt    = bus.par_en;
      stop2_nxt     = bus.stop2;
      msb_nxt       = bus.msb_first;
      parity_nxt    = hold_parity;
    end

    case (state_nxt)
      ST_IDLE:   tx_nxt = 1'b1;
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = msb_nxt ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
      ST_PARITY: tx_nxt = parity_nxt;
      ST_STOP:   tx_nxt = 1'b1;
      default:   tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx_out     = tx_r;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.data_ready = !hold_full;
  assign bus.frame_done = done_r;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_serializer.sv
//==============================================================================
// tb_uart_tx_frame_serializer : self-checking bench with a frame-level model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_uart_tx_frame_serializer;
  localparam int W = 8;
  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_serializer_if #(.WIDTH(W)) bus ();
  uart_tx_frame_serializer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int    checks = 0;
  int    errors = 0;
  int    tick_div = 4;
  bitq_t got;
  int    fd_count = 0;
  int    busy_drops = 0;
  logic  busy_prev = 1'b0;

  initial begin
    int c = 0;
    bus.bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      if (c >= tick_div) begin c = 0; bus.bit_tick = 1'b1; end
      else bus.bit_tick = 1'b0;
    end
  end

  // Line bit of each period is sampled in the cycle its closing tick is high.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus.bit_tick && bus.busy) got.push_back(bus.tx_out);
        if (bus.frame_done) fd_count++;
        if (busy_prev && !bus.busy) busy_drops++;
      end
      busy_prev = bus.busy;
    end
  end

  function automatic bitq_t frame_bits(input logic [W-1:0] d, input bit pe, input bit pt,
                                       input bit s2, input bit msb);
    bitq_t q;
    int ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      bit b = d[msb ? W-1-i : i];
      q.push_back(b);
      ones += int'(b);
    end
    if (pe) q.push_back(pt ? bit'(1 - ones % 2) : bit'(ones % 2));
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    return q;
  endfunction

  function automatic logic [63:0] pack(input bitq_t q);
    logic [63:0] v = '0;
    foreach (q[i]) if (i < 64) v[i] = q[i];
    return v;
  endfunction

  task automatic set_mode(input bit pe, input bit pt, input bit s2, input bit msb);
    bus.par_en = pe; bus.par_typ = pt; bus.stop2 = s2; bus.msb_first = msb;
  endtask

  task automatic clear_obs();
    got.delete();
    fd_count = 0;
    busy_drops = 0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.data_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.data_ready) begin
      checks++; errors++;
      $display("FAIL write_wait: data_ready=%b, required 1 within 2000 cycles", bus.data_ready);
    end
    bus.data = d;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (fd_count < n && k < 3000) begin @(negedge clk); k++; end
    checks++;
    if (fd_count < n) begin
      errors++;
      $display("FAIL frame_timeout: frame_done count=%0d, required %0d", fd_count, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    checks += 4;
    if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", bus.tx_out); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.data_ready); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.frame_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    bitq_t exp = frame_bits(8'hA5, 0, 0, 0, 0);
    tick_div = 4;
    set_mode(0, 0, 0, 0);
    clear_obs();
    write_word(8'hA5);
    wait_frames(1);
    checks += 3;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++; $display("FAIL 8n1_bits: got %0d bits %h, required %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    if (fd_count != 1) begin errors++; $display("FAIL 8n1_done: got %0d pulses, required 1", fd_count); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_parity();
    for (int t = 0; t < 2; t++) begin
      bitq_t exp = frame_bits(8'h07, 1, bit'(t), 1, 0);
      set_mode(1, bit'(t), 1, 0);
      clear_obs();
      write_word(8'h07);
      wait_frames(1);
      checks += 2;
      if (got.size() != 12) begin errors++; $display("FAIL parity_len%0d: got %0d ticks, required 12", t, got.size()); end
      if (pack(got) !== pack(exp)) begin
        errors++; $display("FAIL parity_bits%0d: got %h, required %h", t, pack(got), pack(exp));
      end
    end
  endtask

  task automatic test_msb_first();
    bitq_t exp = frame_bits(8'h80, 0, 0, 0, 1);
    set_mode(0, 0, 0, 1);
    clear_obs();
    write_word(8'h80);
    wait_frames(1);
    checks++;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++; $display("FAIL msb_bits: got %0d bits %h, required %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
  endtask

  task automatic test_back_to_back();
    bitq_t exp = frame_bits(8'h11, 0, 0, 0, 0);
    bitq_t e2 = frame_bits(8'h22, 0, 0, 0, 0);
    int n = 0;
    foreach (e2[i]) exp.push_back(e2[i]);
    set_mode(0, 0, 0, 0);
    clear_obs();
    write_word(8'h11);
    while (!bus.busy && n < 100) begin @(negedge clk); n++; end
    write_word(8'h22);
    checks++;
    if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b, required 0", bus.data_ready); end
    bus.data = 8'h33;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    wait_frames(2);
    repeat (100) @(negedge clk);
    checks += 4;
    if (pack(got) !== pack(exp) || got.size() != exp.size()) begin
      errors++; $display("FAIL b2b_bits: got %0d bits %h, required %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    if (fd_count != 2) begin errors++; $display("FAIL b2b_done: got %0d pulses, required 2", fd_count); end
    if (busy_drops != 1) begin errors++; $display("FAIL b2b_gap: busy fell %0d times, required 1", busy_drops); end
    if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end: got %b, required 1", bus.data_ready); end
  endtask

  task automatic test_reset_mid();
    bitq_t exp = frame_bits(8'h3C, 0, 0, 0, 0);
    int n = 0;
    set_mode(0, 0, 0, 0);
    clear_obs();
    write_word(8'h00);
    write_word(8'hFF);
    while (got.size() < 4 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b, required 1", bus.tx_out); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
    if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, required 1", bus.data_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    clear_obs();
    write_word(8'h3C);
    wait_frames(1);
    repeat (40) @(negedge clk);
    checks += 2;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++; $display("FAIL midrst_after: got %0d bits %h, required %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    if (fd_count != 1) begin errors++; $display("FAIL midrst_done: got %0d pulses, required 1", fd_count); end
  endtask

  task automatic test_load_tick_mode();
    bitq_t exp = frame_bits(8'hC6, 1, 1, 1, 1);
    tick_div = 1;
    set_mode(1, 1, 1, 1);
    clear_obs();
    write_word(8'hC6);
    repeat (3) @(negedge clk);
    set_mode(0, 0, 0, 0);
    wait_frames(1);
    checks++;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++; $display("FAIL latch_mode: got %0d bits %h, required %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    tick_div = 4;
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      logic [W-1:0] d = W'($urandom);
      bit pe = bit'($urandom_range(0, 1));
      bit pt = bit'($urandom_range(0, 1));
      bit s2 = bit'($urandom_range(0, 1));
      bit msb = bit'($urandom_range(0, 1));
      bitq_t exp = frame_bits(d, pe, pt, s2, msb);
      tick_div = $urandom_range(1, 6);
      set_mode(pe, pt, s2, msb);
      clear_obs();
      write_word(d);
      wait_frames(1);
      checks += 2;
      if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
        errors++; $display("FAIL rand%0d_bits: data %h got %0d bits %h, required %0d bits %h", r, d, got.size(), pack(got), exp.size(), pack(exp));
      end
      if (fd_count != 1) begin errors++; $display("FAIL rand%0d_done: got %0d pulses, required 1", r, fd_count); end
    end
  endtask

  initial begin
    bus.data = '0;
    bus.data_valid = 1'b0;
    set_mode(0, 0, 0, 0);
    test_reset();
    test_8n1();
    test_parity();
    test_msb_first();
    test_back_to_back();
    test_reset_mid();
    test_load_tick_mode();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
